// File: rtl/ez8_pkg.sv
// ez8 shared package: loader FSM state encoding and default widths.
// RDBK/CMP states are present only when MEM_LOADER_VERIFY_EN is defined.
package ez8_pkg;

  localparam int EZ8_ADDR_W = 8;
  localparam int EZ8_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef MEM_LOADER_VERIFY_EN
    S_RDBK,
    S_CMP,
`endif
    S_FIN
  } ld_state_t;

endpackage

// File: rtl/mem_loader.sv
// Stream-to-memory loader: one byte per RECV/WRITE pair.
// Optional write-readback verify enabled by MEM_LOADER_VERIFY_EN.
module mem_loader
  import ez8_pkg::*;
#(
  parameter int ADDR_WIDTH = EZ8_ADDR_W,
  parameter int DATA_WIDTH = EZ8_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] writeaddr,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] readaddr,
  input  logic [DATA_WIDTH-1:0] readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int RW = ADDR_WIDTH + 1;

  ld_state_t             state_q;
  ld_state_t             state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [RW-1:0]         rem_q;
  logic                  accept;
  logic                  last;

  assign accept = (state_q == S_RECV) && in_valid;
  assign last   = (rem_q == RW'(1));

  assign in_ready  = (state_q == S_RECV);
  assign mem_write = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign writeaddr = addr_q;
  assign writedata = data_q;
  assign count     = count_q;

`ifdef MEM_LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] rdaddr_q;
  logic                  err_q;
  logic                  match;

  assign match    = (readdata == data_q);
  assign readaddr = rdaddr_q;
  assign error    = err_q;
`else
  logic unused_readdata;

  assign unused_readdata = ^readdata;
  assign readaddr        = '0;
  assign error           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RECV;
      S_RECV:  if (in_valid) state_d = S_WRITE;
`ifdef MEM_LOADER_VERIFY_EN
      S_WRITE: state_d = S_RDBK;
      S_RDBK:  state_d = S_CMP;
      S_CMP: begin
        // a mismatch aborts the rest of the load
        if (!match || rem_q == '0) state_d = S_FIN;
        else state_d = S_RECV;
      end
`else
      S_WRITE: state_d = last ? S_FIN : S_RECV;
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q  <= base_addr;
        count_q <= '0;
        // zero length encodes a full 2^ADDR_WIDTH load
        rem_q   <= (length == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                  : {1'b0, length};
      end
      if (accept) data_q <= in_data;
      if (state_q == S_WRITE) begin
        addr_q  <= addr_q + ADDR_WIDTH'(1);
        count_q <= count_q + ADDR_WIDTH'(1);
        rem_q   <= rem_q - RW'(1);
      end
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdaddr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) err_q <= 1'b0;
      if (state_q == S_WRITE) rdaddr_q <= addr_q;
      if (state_q == S_CMP && !match) err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a simple memory model.
// Verify-path checks compile only with MEM_LOADER_VERIFY_EN.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] writeaddr;
  logic [7:0] writedata;
  logic       mem_write;
  logic [7:0] readaddr;
  logic [7:0] readdata;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] count;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic       corrupt = 1'b0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         done_cnt = 0;
  int         dbl = 0;
  logic       prev_mw = 1'b0;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .writeaddr(writeaddr), .writedata(writedata),
    .mem_write(mem_write), .readaddr(readaddr),
    .readdata(readdata), .busy(busy), .done(done),
    .error(error), .count(count)
  );

  always @(posedge clk) begin
    if (mem_write)
      mem[writeaddr] <= (corrupt && writeaddr == 8'h21)
                        ? ~writedata : writedata;
    readdata <= mem[readaddr];
  end

  always @(negedge clk) begin
    if (mem_write) begin
      wa.push_back(writeaddr);
      wd.push_back(writedata);
      if (prev_mw) dbl++;
    end
    prev_mw = mem_write;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    done_cnt = 0;
    dbl = 0;
  endtask

  task automatic go(input logic [7:0] b, input logic [7:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(tag, done, 1);
    tick();
    check({tag, "_1cyc"}, done, 0);
    tick();
  endtask

  initial begin
    int bad;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = 8'h00;
    length = 8'h00;
    in_data = 8'h00;
    in_valid = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_mw", mem_write, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_cnt", count, 0);
    check("rst_wa", writeaddr, 0);
    check("rst_wd", writedata, 0);
    check("rst_ra", readaddr, 0);
    reset_n = 1'b1;
    tick();

    // basic three-byte load
    clr();
    go(8'h10, 8'd3);
    check("t1_busy", busy, 1);
    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    wait_done("t1_done", 20);
    check("t1_n", wa.size(), 3);
    check("t1_a0", wa[0], 8'h10);
    check("t1_d0", wd[0], 8'hA1);
    check("t1_a1", wa[1], 8'h11);
    check("t1_d1", wd[1], 8'hB2);
    check("t1_a2", wa[2], 8'h12);
    check("t1_d2", wd[2], 8'hC3);
    check("t1_cnt", count, 3);
    check("t1_dcnt", done_cnt, 1);
    check("t1_dbl", dbl, 0);
    check("t1_idle", busy, 0);

    // address wrap
    clr();
    go(8'hFE, 8'd4);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    wait_done("t2_done", 20);
    check("t2_n", wa.size(), 4);
    check("t2_a0", wa[0], 8'hFE);
    check("t2_a1", wa[1], 8'hFF);
    check("t2_a2", wa[2], 8'h00);
    check("t2_a3", wa[3], 8'h01);
    check("t2_d3", wd[3], 8'h04);
    check("t2_cnt", count, 4);

    // length 0 means 256
    clr();
    go(8'h05, 8'd0);
    for (int i = 0; i < 256; i++) send(8'(i));
    wait_done("t3_done", 20);
    check("t3_n", wa.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (wa[i] !== 8'(5 + i) || wd[i] !== 8'(i)) bad++;
    check("t3_log", bad, 0);
    check("t3_cnt", count, 0);
    check("t3_dcnt", done_cnt, 1);
    check("t3_dbl", dbl, 0);

    // in_valid ignored in IDLE, start ignored while busy, gaps
    clr();
    in_valid = 1'b1;
    in_data = 8'h99;
    repeat (3) tick();
    check("t4_idle_rdy", in_ready, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_n", wa.size(), 0);
    in_valid = 1'b0;
    go(8'h40, 8'd2);
    send(8'h11);
    tick();
    go(8'h80, 8'd9);
    repeat (5) tick();
    check("t4_gap_rdy", in_ready, 1);
    check("t4_gap_n", wa.size(), 1);
    send(8'h22);
    wait_done("t4_done", 20);
    check("t4_n", wa.size(), 2);
    check("t4_a0", wa[0], 8'h40);
    check("t4_a1", wa[1], 8'h41);
    check("t4_d1", wd[1], 8'h22);
    check("t4_cnt", count, 2);

    // reset mid-load
    clr();
    go(8'h50, 8'd3);
    send(8'h01);
    send(8'h02);
    check("t5_pre_mw", mem_write, 1);
    reset_n = 1'b0;
    #1;
    check("t5_mw", mem_write, 0);
    check("t5_busy", busy, 0);
    check("t5_cnt", count, 0);
    check("t5_rdy", in_ready, 0);
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (6) tick();
    in_valid = 1'b0;
    check("t5_post_n", wa.size(), 1);
    check("t5_post_busy", busy, 0);
    clr();
    go(8'h60, 8'd2);
    send(8'h5A);
    send(8'hA5);
    wait_done("t5_done", 20);
    check("t5_n", wa.size(), 2);
    check("t5_a0", wa[0], 8'h60);
    check("t5_d0", wd[0], 8'h5A);
    check("t5_a1", wa[1], 8'h61);
    check("t5_d1", wd[1], 8'hA5);

`ifdef MEM_LOADER_VERIFY_EN
    // readback mismatch at 0x21 aborts the load
    clr();
    corrupt = 1'b1;
    go(8'h20, 8'd4);
    send(8'h11);
    send(8'h22);
    wait_done("t6_done", 20);
    check("t6_err", error, 1);
    check("t6_n", wa.size(), 2);
    check("t6_a1", wa[1], 8'h21);
    check("t6_cnt", count, 2);
    check("t6_dcnt", done_cnt, 1);
    repeat (3) tick();
    check("t6_sticky", error, 1);
    check("t6_n2", wa.size(), 2);
    corrupt = 1'b0;
    clr();
    go(8'h30, 8'd1);
    check("t6_clr", error, 0);
    send(8'h77);
    wait_done("t6_done2", 20);
    check("t6_err2", error, 0);
    check("t6_a", wa[0], 8'h30);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
